// File: rtl/audio_pkg.sv
// Shared types for the square-wave audio path: sequencer state encoding and
// the note-table entry layout at the default field widths.
package audio_pkg;

  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_DUR_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [DEF_PERIOD_W-1:0] period;
    logic [DEF_DUR_W-1:0]    dur;
  } note_t;

endpackage

// File: rtl/tone_osc.sv
// Square-wave oscillator: pwm toggles every `period` cycles while enabled.
// Disabling clears the phase so the next enable starts low at count 0.
module tone_osc #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                pwm
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                pwm_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else if (cnt_q == period - PERIOD_W'(1)) begin
      cnt_q <= '0;
      pwm_q <= ~pwm_q;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

  // Gating with en forces pwm low in the same cycle the enable drops.
  assign pwm = pwm_q & en;

endmodule

// File: rtl/tone_sequencer.sv
// Plays a writable table of (half-period, duration) notes through tone_osc,
// with an optional silent gap after each note and looping at end of sequence.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int NOTES     = 16,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int DUR_W     = DEF_DUR_W,
  parameter int TICK_DIV  = 21477,
  parameter int GAP_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     skip,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [PERIOD_W-1:0]      wr_period,
  input  logic [DUR_W-1:0]         wr_dur,
  output logic                     tone_en,
  output logic [PERIOD_W-1:0]      tone_period,
  output logic                     pwm,
  output logic                     busy,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic                     done,
  output seq_state_t               dbg_state
);

  localparam int IDX_W = $clog2(NOTES);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NOTES - 1);
  localparam logic [DUR_W-1:0] GAP_CNT = DUR_W'(GAP_TICKS);

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    dur;
  } entry_t;

  entry_t              mem_q [NOTES];
  entry_t              rd_q;
  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                tone_en_q;
  logic [PERIOD_W-1:0] tone_period_q;
  logic                busy_q;
  logic                done_q;
  logic                tick;
  logic                advance;

  // Read address is the next index, so the entry is ready during LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= '{period: wr_period, dur: wr_dur};
    rd_q <= mem_q[idx_d];
  end

  assign tick = (presc_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    advance = 1'b0;
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (rd_q.dur != '0) begin
          state_d = PLAY;
          rem_d   = rd_q.dur;
        end else if (loop && idx_q != '0) begin
          idx_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      PLAY: begin
        if (skip) begin
          advance = 1'b1;
        end else if (tick) begin
          if (rem_q == DUR_W'(1)) begin
            if (GAP_TICKS > 0) begin
              state_d = GAP;
              rem_d   = GAP_CNT;
            end else begin
              advance = 1'b1;
            end
          end else begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (skip) begin
          advance = 1'b1;
        end else if (tick) begin
          if (rem_q == DUR_W'(1)) advance = 1'b1;
          else rem_d = rem_q - DUR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q != IDX_MAX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = LOAD;
      end else if (loop) begin
        idx_d   = '0;
        state_d = LOAD;
      end else begin
        state_d = DONE;
      end
    end

    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
    end

    // Restarting the prescaler on every state change makes each tick exact.
    if (state_d != state_q) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rem_q         <= '0;
      presc_q       <= '0;
      tone_en_q     <= 1'b0;
      tone_period_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      presc_q       <= presc_d;
      tone_en_q     <= (state_d == PLAY) &&
                       ((state_q == PLAY) ? tone_en_q : (rd_q.period != '0));
      tone_period_q <= (state_d != PLAY) ? '0 :
                       ((state_q == PLAY) ? tone_period_q : rd_q.period);
      busy_q        <= (state_d != IDLE);
      done_q        <= (state_d == DONE);
    end
  end

  tone_osc #(
    .PERIOD_W(PERIOD_W)
  ) u_osc (
    .clk   (clk),
    .rst   (rst),
    .en    (tone_en_q),
    .period(tone_period_q),
    .pwm   (pwm)
  );

  assign tone_en     = tone_en_q;
  assign tone_period = tone_period_q;
  assign busy        = busy_q;
  assign note_idx    = idx_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a timeline model expands the note table into the
// expected per-cycle output words, which are compared as the DUT plays.
module tb_tone_sequencer;
  import audio_pkg::*;

  localparam int NOTES = 4;
  localparam int TD    = 4;
  localparam int GT    = 1;
  localparam int W     = 22;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop, skip, wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_period;
  logic [7:0]  wr_dur;
  logic        tone_en, pwm, busy, done;
  logic [15:0] tone_period;
  logic [1:0]  note_idx;
  seq_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  note_t tbl [NOTES];

  tone_sequencer #(
    .NOTES(NOTES), .PERIOD_W(16), .DUR_W(8), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .skip(skip),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period), .wr_dur(wr_dur),
    .tone_en(tone_en), .tone_period(tone_period), .pwm(pwm), .busy(busy),
    .note_idx(note_idx), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(bit d, bit b, bit e, bit p, int i, int per);
    return {d, b, e, p, 2'(i), 16'(per)};
  endfunction

  function automatic logic [W-1:0] sample();
    return {done, busy, tone_en, pwm, note_idx, tone_period};
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic write_entry(input int a, input int p, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_period = 16'(p); wr_dur = 8'(d);
    tbl[a] = '{period: 16'(p), dur: 8'(d)};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_table(input int p0, d0, p1, d1, p2, d2, p3, d3);
    write_entry(0, p0, d0);
    write_entry(1, p1, d1);
    write_entry(2, p2, d2);
    write_entry(3, p3, d3);
  endtask

  // Expected timeline from start; trunc0 >= 0 cuts the first play of entry 0
  // to that many cycles (skip) with no gap after it.
  task automatic build_trace(input bit lp, input int max_c, input int trunc0);
    int idx = 0;
    int n = 0;
    bit fin = 1'b0;
    bit first = 1'b1;
    while (!fin && n < max_c) begin
      exp_q.push_back(mk(0, 1, 0, 0, idx, 0)); n++;
      if (tbl[idx].dur == 0) begin
        if (lp && idx != 0) idx = 0;
        else fin = 1'b1;
      end else begin
        int p, len;
        bit cut, en;
        p   = int'(tbl[idx].period);
        cut = (idx == 0) && first && (trunc0 >= 0);
        len = cut ? trunc0 : int'(tbl[idx].dur) * TD;
        en  = (p != 0);
        for (int c = 0; c < len && n < max_c; c++) begin
          exp_q.push_back(mk(0, 1, en, en ? ((c / p) % 2) : 0, idx, p)); n++;
        end
        if (!cut)
          for (int c = 0; c < GT * TD && n < max_c; c++) begin
            exp_q.push_back(mk(0, 1, 0, 0, idx, 0)); n++;
          end
        if (idx == 0) first = 1'b0;
        if (idx < NOTES - 1) idx++;
        else if (lp) idx = 0;
        else fin = 1'b1;
      end
    end
    if (fin) begin
      exp_q.push_back(mk(1, 1, 0, 0, idx, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] o;
    rst = 1'b1; start = 0; stop = 0; loop = 0; skip = 0;
    wr_en = 0; wr_addr = 0; wr_period = 0; wr_dur = 0;
    @(negedge clk); @(negedge clk);
    o = sample(); n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", o); end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name, input bit lp);
    logic [W-1:0] e, o;
    int i = 0;
    loop = lp;
    build_trace(lp, 100, -1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s cyc %0d got %h exp %h", name, i, o, e); end
      i++;
      @(negedge clk);
    end
    if (lp) begin
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      o = sample(); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL %s_stop got %h exp 0", name, o); end
    end
    loop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort(input string name, input bit use_rst);
    logic [W-1:0] e, o;
    int i = 0;
    build_trace(0, 6, -1);
    for (int k = 0; k < 3; k++) exp_q.push_back('0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s cyc %0d got %h exp %h", name, i, o, e); end
      if (i == 5) begin if (use_rst) rst = 1'b1; else stop = 1'b1; end
      if (i == 6) begin rst = 1'b0; stop = 1'b0; end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_skip();
    logic [W-1:0] e, o;
    int i = 0;
    build_trace(0, 200, 3);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL skip cyc %0d got %h exp %h", i, o, e); end
      if (i == 3) skip = 1'b1;
      if (i == 4) skip = 1'b0;
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_stop();
    logic [W-1:0] o;
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      o = sample(); n_checks++;
      if (o !== '0 || dbg_state !== IDLE) begin
        n_fail++; $display("FAIL start_stop cyc %0d got %h state %0d exp 0 IDLE", k, o, dbg_state);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_during_play();
    logic [W-1:0] e, o;
    int i = 0;
    tbl[1] = '{period: 16'd3, dur: 8'd1};
    build_trace(0, 200, -1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wr_play cyc %0d got %h exp %h", i, o, e); end
      if (i == 2) begin wr_en = 1'b1; wr_addr = 2'd1; wr_period = 16'd3; wr_dur = 8'd1; end
      if (i == 3) wr_en = 1'b0;
      i++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    load_table(10, 2, 0, 1, 20, 1, 0, 0);
    test_basic("marker_once", 1'b0);
    test_basic("marker_loop", 1'b1);
    test_abort("stop_mid_play", 1'b0);
    test_skip();
    test_abort("rst_mid_play", 1'b1);
    test_start_stop();
    load_table(3, 1, 2, 2, 5, 1, 1, 1);
    test_basic("full_once", 1'b0);
    test_basic("full_loop", 1'b1);
    load_table(2, 2, 0, 1, 20, 1, 0, 0);
    test_write_during_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller that sequences the square-wave audio path: steps through a writable note table of (period, duration) entries.
- Drives the internal tone oscillator's period and enable, and produces the 1-bit `pwm` that feeds `aud_pwm`.
- Replaces direct button-driven tone selection in audio bring-up tops; later serves as a test-melody source alongside the APU.

Parameters:
- NOTES, 16, note-table depth (power of 2).
- PERIOD_W, 16, width of half-period in clk cycles.
- DUR_W, 8, width of note duration in ticks.
- TICK_DIV, 21477, clk cycles per duration tick.
- GAP_TICKS, 1, silent ticks inserted after each note (0 = legato).

Ports:
- clk  in  1  system clock (clk_ppu8 domain).
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin playback from entry 0; ignored unless IDLE.
- stop  in  1  abort playback; priority over start and skip.
- loop  in  1  sampled at each end-of-sequence: 1 = restart at entry 0.
- skip  in  1  end current note/gap immediately.
- wr_en  in  1  note-table write strobe.
- wr_addr  in  $clog2(NOTES)  write address.
- wr_period  in  PERIOD_W  half-period; 0 = rest.
- wr_dur  in  DUR_W  duration in ticks; 0 = end-of-sequence marker.
- tone_en  out  1  oscillator enable.
- tone_period  out  PERIOD_W  current half-period.
- pwm  out  1  square-wave audio output.
- busy  out  1  high in any state except IDLE.
- note_idx  out  $clog2(NOTES)  current table index.
- done  out  1  one-cycle pulse at natural end of sequence.

Behaviour:
- Reset: state = IDLE. All outputs 0; tick prescaler and oscillator counters cleared. Table contents are not reset.
- Table: synchronous write. Registered read of entry `note_idx` takes 1 cycle. Same-cycle write/read of one address returns the old data. Writes are allowed while busy and take effect the next time that entry is loaded.
- Tick prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap. Cleared on entry to PLAY and GAP, so one duration tick = exactly TICK_DIV cycles.
- IDLE:
  - start (and no stop) -> LOAD, idx = 0.
  - tone_en = 0, busy = 0.
- LOAD (1 cycle): latch period/dur from the read data.
  - dur != 0 -> PLAY, remaining = dur.
  - dur == 0 and loop and idx != 0 -> idx = 0, LOAD.
  - dur == 0 otherwise -> DONE.
- PLAY:
  - tone_en = (period != 0); tone_period = latched period.
  - Each tick decrements remaining. At the tick that makes it 0: -> GAP if GAP_TICKS > 0, else ADVANCE.
- GAP: tone_en = 0 for GAP_TICKS ticks, then ADVANCE.
- ADVANCE (combinational action on the exiting cycle, not a state):
  - idx < NOTES-1 -> idx+1, LOAD.
  - idx == NOTES-1 and loop -> idx = 0, LOAD.
  - idx == NOTES-1 and !loop -> DONE.
- skip in PLAY or GAP -> ADVANCE on that cycle. skip elsewhere is ignored.
- DONE (1 cycle): done = 1, tone_en = 0, then IDLE.
- stop in any state -> IDLE next cycle: tone_en = 0, pwm = 0, no done pulse.
- Latency: start sampled at cycle N -> LOAD at N+1 -> tone_en, tone_period valid at N+2. Outputs are registered.
- Oscillator:
  - While tone_en: counter 0..tone_period-1; pwm toggles on wrap. Output frequency = clk / (2 × period).
  - While !tone_en: counter = 0, pwm = 0.
  - Every note boundary passes through LOAD with tone_en = 0, so each note starts in phase with pwm = 0.

Decomposition:
- Package `audio_pkg`: state enum `seq_state_t` {IDLE, LOAD, PLAY, GAP, DONE}; `note_t` struct {period, dur}; default PERIOD_W/DUR_W constants.
- Sub-module `tone_osc`: clk, rst, en, period -> pwm. Reusable by the APU debug path.

Test Plan (NOTES = 4, TICK_DIV = 4, GAP_TICKS = 1):
- Table {(10,2),(0,1),(20,1),(x,0)}, loop = 0, pulse start:
  - tone_en high 8 cycles starting 2 cycles after start; pwm toggles every 10 cycles.
  - 4-cycle gap; rest entry gives 4 cycles tone_en = 0 plus gap.
  - tone_period = 20 for 4 cycles, then gap; one done pulse; busy = 0.
- Same table, loop = 1 -> after entry 2 and its gap, LOAD idx 3, LOAD idx 0, entry 0 replays; no done pulse over 3 iterations.
- stop asserted mid-PLAY of entry 0 -> next cycle tone_en = 0, pwm = 0, busy = 0, done never asserted.
- skip on the 3rd cycle of entry 0 -> next cycle LOAD with note_idx = 1; entry-0 pwm truncated.
- Table fully non-zero (no marker):
  - loop = 0 -> done after idx 3.
  - loop = 1 -> note_idx wraps 3 -> 0.
- rst mid-PLAY -> all outputs 0 next cycle.
- start and stop in the same cycle -> stays IDLE.
- Write entry 1 while entry 0 plays -> new values heard at entry 1.
